// File: rtl/ifft_frame_gen.sv
// Builds one Hermitian odd-harmonic frequency frame per request and streams it to an IFFT over AXI-Stream.
// Optional build macro IFFT_FRAME_GEN_DC_OFFSET_EN adds a signed dc_offset port that sets beat 0.
module ifft_frame_gen #(
    parameter int unsigned N_FFT    = 1024,
    parameter int unsigned LOG2N    = 10,
    parameter int unsigned MAX_HARM = 8,
    parameter int unsigned DW       = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          wave_type,
    input  logic [LOG2N-1:0]    freq_bin,
    input  logic [15:0]         amp,
`ifdef IFFT_FRAME_GEN_DC_OFFSET_EN
    input  logic signed [15:0]  dc_offset,
`endif
    input  logic                cfg_tready,
    output logic [2*DW-1:0]     m_axis_data_tdata,
    output logic                m_axis_data_tvalid,
    input  logic                m_axis_data_tready,
    output logic                m_axis_data_tlast,
    output logic                busy,
    output logic                done
);

    localparam int unsigned HIW  = (MAX_HARM > 1) ? $clog2(MAX_HARM) : 1;
    localparam int unsigned HCW  = $clog2(MAX_HARM + 1);
    localparam int unsigned NW   = $clog2(2 * MAX_HARM);
    localparam int unsigned PW   = LOG2N + NW + 1;
    localparam int unsigned HALF = N_FFT / 2;

    localparam logic [1:0] WT_SINE   = 2'd0;
    localparam logic [1:0] WT_SQUARE = 2'd1;
    localparam logic [1:0] WT_NONE   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_STREAM, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_accept_start;

    logic [1:0]         r_wave;
    logic [LOG2N-1:0]   r_k;
    logic [15:0]        r_amp;
`ifdef IFFT_FRAME_GEN_DC_OFFSET_EN
    logic [15:0]        r_dc;
`endif

    logic [HIW-1:0]     r_h;
    logic [PW-1:0]      r_p;
    logic [HCW-1:0]     r_nval;
    logic [LOG2N-1:0]   r_bin [MAX_HARM];
    logic [LOG2N-1:0]   r_pm  [MAX_HARM];
    logic [DW-1:0]      r_mag [MAX_HARM];

    logic [LOG2N-1:0]   r_idx;
    logic [HCW-1:0]     r_lo;
    logic [HCW-1:0]     r_hi;
    logic               r_last_loaded;

    logic [DW-1:0]      r_re;
    logic               r_tvalid;
    logic               r_tlast;
    logic               r_busy;
    logic               r_done;

    logic [15:0]        w_recip;
    logic [31:0]        w_prod;
    logic [15:0]        w_mag_u;
    logic [DW-1:0]      w_mag_ext;
    logic [DW-1:0]      w_mag_s;
    logic               w_slot_ok;
    logic [LOG2N-1:0]   w_pm;
    logic [PW-1:0]      w_p_step;

    logic [HIW-1:0]     w_lo_ix;
    logic [HIW-1:0]     w_hi_ix;
    logic               w_lo_hit;
    logic               w_hi_hit;
    logic [DW-1:0]      w_dc;
    logic [DW-1:0]      w_beat;
    logic               w_load;
    logic               w_beat_acc;

    // Q15 reciprocal ROM: 1/n for square, 1/n^2 for triangle, unity for the sine fundamental
    function automatic logic [15:0] f_recip(input logic [1:0] wt, input logic [HIW-1:0] h);
        logic [15:0] r;
        r = 16'd0;
        if (wt == WT_SINE) begin
            r = 16'd32768;
        end else if (wt == WT_SQUARE) begin
            case (32'(h))
                0:       r = 16'd32768;
                1:       r = 16'd10923;
                2:       r = 16'd6554;
                3:       r = 16'd4681;
                4:       r = 16'd3641;
                5:       r = 16'd2979;
                6:       r = 16'd2521;
                7:       r = 16'd2185;
                default: r = 16'd0;
            endcase
        end else if (wt == 2'd2) begin
            case (32'(h))
                0:       r = 16'd32768;
                1:       r = 16'd3641;
                2:       r = 16'd1311;
                3:       r = 16'd669;
                4:       r = 16'd405;
                5:       r = 16'd271;
                6:       r = 16'd194;
                7:       r = 16'd146;
                default: r = 16'd0;
            endcase
        end
        return r;
    endfunction

    // Slot preparation datapath, one harmonic per PREP cycle
    assign w_recip   = f_recip(r_wave, r_h);
    assign w_prod    = 32'(r_amp) * 32'(w_recip);
    assign w_mag_u   = 16'(w_prod >> 15);
    assign w_mag_ext = DW'(w_mag_u);
    assign w_mag_s   = (r_wave == WT_SQUARE && r_h[0]) ? (~w_mag_ext + DW'(1)) : w_mag_ext;
    assign w_slot_ok = (r_wave != WT_NONE) && (r_p != '0) && (r_p < PW'(HALF)) &&
                       ((r_wave != WT_SINE) || (r_h == '0));
    assign w_pm      = LOG2N'(PW'(N_FFT) - r_p);
    assign w_p_step  = PW'({r_k, 1'b0});

    // Valid slots form a prefix with ascending bins: lower half walks up, mirror half walks down
    assign w_lo_ix  = HIW'(r_lo);
    assign w_hi_ix  = HIW'(r_hi - HCW'(1));
    assign w_lo_hit = (r_lo < r_nval) && (r_bin[w_lo_ix] == r_idx);
    assign w_hi_hit = (r_hi != '0) && (r_pm[w_hi_ix] == r_idx);

`ifdef IFFT_FRAME_GEN_DC_OFFSET_EN
    assign w_dc = {{(DW-16){r_dc[15]}}, r_dc};
`else
    assign w_dc = '0;
`endif

    always_comb begin
        w_beat = '0;
        if (r_idx == '0) begin
            w_beat = w_dc;
        end else if (w_lo_hit) begin
            w_beat = r_mag[w_lo_ix];
        end else if (w_hi_hit) begin
            w_beat = r_mag[w_hi_ix];
        end
    end

    assign w_beat_acc = r_tvalid && m_axis_data_tready;
    assign w_load     = (r_state == S_STREAM) && !r_last_loaded &&
                        (!r_tvalid || m_axis_data_tready);

    // Next-state logic
    always_comb begin
        w_next         = r_state;
        w_accept_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && cfg_tready) begin
                    w_next         = S_PREP;
                    w_accept_start = 1'b1;
                end
            end
            S_PREP: begin
                if (r_h == HIW'(MAX_HARM - 1)) begin
                    w_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_beat_acc && r_tlast) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch, harmonic table and stream pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wave        <= '0;
            r_k           <= '0;
            r_amp         <= '0;
`ifdef IFFT_FRAME_GEN_DC_OFFSET_EN
            r_dc          <= '0;
`endif
            r_h           <= '0;
            r_p           <= '0;
            r_nval        <= '0;
            r_idx         <= '0;
            r_lo          <= '0;
            r_hi          <= '0;
            r_last_loaded <= 1'b0;
            for (int i = 0; i < MAX_HARM; i++) begin
                r_bin[i] <= '0;
                r_pm[i]  <= '0;
                r_mag[i] <= '0;
            end
        end else begin
            if (w_accept_start) begin
                r_wave        <= wave_type;
                r_k           <= freq_bin;
                r_amp         <= amp;
`ifdef IFFT_FRAME_GEN_DC_OFFSET_EN
                r_dc          <= dc_offset;
`endif
                r_h           <= '0;
                r_p           <= PW'(freq_bin);
                r_nval        <= '0;
                r_idx         <= '0;
                r_lo          <= '0;
                r_hi          <= '0;
                r_last_loaded <= 1'b0;
            end
            if (r_state == S_PREP) begin
                r_bin[r_h] <= LOG2N'(r_p);
                r_pm[r_h]  <= w_pm;
                r_mag[r_h] <= w_mag_s;
                if (w_slot_ok) begin
                    r_nval <= r_nval + HCW'(1);
                end
                r_p <= r_p + w_p_step;
                r_h <= r_h + HIW'(1);
            end
            if (w_load) begin
                r_idx <= r_idx + LOG2N'(1);
                if (r_idx == LOG2N'(N_FFT - 1)) begin
                    r_last_loaded <= 1'b1;
                end
                if (w_lo_hit) begin
                    r_lo <= r_lo + HCW'(1);
                end
                if (r_idx == '0) begin
                    r_hi <= r_nval;
                end else if (w_hi_hit) begin
                    r_hi <= r_hi - HCW'(1);
                end
            end
        end
    end

    // Registered stream and status outputs; beat register only reloads when empty or accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_re     <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE);
            if (w_load) begin
                r_tvalid <= 1'b1;
                r_re     <= w_beat;
                r_tlast  <= (r_idx == LOG2N'(N_FFT - 1));
            end else if (w_beat_acc) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
        end
    end

    assign m_axis_data_tdata  = {{DW{1'b0}}, r_re};
    assign m_axis_data_tvalid = r_tvalid;
    assign m_axis_data_tlast  = r_tlast;
    assign busy               = r_busy;
    assign done               = r_done;

endmodule
